// File: rtl/tx_symbol_scheduler.sv
// Symbol scheduler feeding the 8b/10b encoder: arbitrates link data, periodic
// SKP ordered sets and the compliance pattern, filling gaps with logical idle.
module tx_symbol_scheduler #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_COUNT    = 3,
  parameter int unsigned CNT_W        = 11
) (
  input  logic       INTERCLK,
  input  logic       Reset,
  input  logic       iEnable,
  input  logic       iCompliance,
  input  logic [7:0] iData,
  input  logic       iDataK,
  input  logic       iLast,
  input  logic       iValid,
  output logic       oReady,
  output logic [7:0] oTxData,
  output logic       oTxDataK,
  output logic       oTxComp,
  output logic       oSkpActive,
  output logic [1:0] oState
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DATA = 2'd1,
    ST_SKP  = 2'd2,
    ST_COMP = 2'd3
  } state_t;

  localparam logic [7:0]       SYM_COM  = 8'hBC;
  localparam logic [7:0]       SYM_SKP  = 8'h1C;
  localparam logic [2:0]       SUB_LAST = 3'(SKP_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKP_INTERVAL - 1);

  state_t           r_state;
  state_t           r_ostate;
  logic [CNT_W-1:0] r_cnt;
  logic             r_skp_pending;
  logic             r_in_packet;
  logic [2:0]       r_sub;
  logic [7:0]       r_txdata;
  logic             r_txk;
  logic             r_txcomp;
  logic             r_skpact;

  logic             w_ready;
  logic             w_xfer;
  logic [7:0]       w_pat_d;
  logic             w_pat_k;
  logic             w_pat_c;

  assign w_ready = iEnable & ~iCompliance & (r_state == ST_DATA) &
                   ~(r_skp_pending & ~r_in_packet);
  assign w_xfer  = iValid & w_ready;

  always_comb begin
    w_pat_d = SYM_COM;
    w_pat_k = 1'b1;
    w_pat_c = 1'b0;
    case (r_sub[1:0])
      2'd0: w_pat_c = 1'b1;
      2'd1: begin w_pat_d = 8'hB5; w_pat_k = 1'b0; end
      2'd2: ;
      2'd3: begin w_pat_d = 8'h4A; w_pat_k = 1'b0; end
    endcase
  end

  // r_ostate tracks the symbol on oTxData; it leads r_state on entry edges
  // (COM / first compliance symbol are emitted by the cycle that decides).
  always_ff @(posedge INTERCLK or negedge Reset) begin
    if (!Reset) begin
      r_state       <= ST_OFF;
      r_ostate      <= ST_OFF;
      r_cnt         <= '0;
      r_skp_pending <= 1'b0;
      r_in_packet   <= 1'b0;
      r_sub         <= '0;
      r_txdata      <= '0;
      r_txk         <= 1'b0;
      r_txcomp      <= 1'b0;
      r_skpact      <= 1'b0;
    end else begin
      r_txdata <= '0;
      r_txk    <= 1'b0;
      r_txcomp <= 1'b0;
      r_skpact <= 1'b0;
      if (!iEnable) begin
        r_state       <= ST_OFF;
        r_ostate      <= ST_OFF;
        r_cnt         <= '0;
        r_skp_pending <= 1'b0;
        r_in_packet   <= 1'b0;
        r_sub         <= '0;
      end else begin
        case (r_state)
          ST_OFF: begin
            r_state  <= ST_DATA;
            r_ostate <= ST_DATA;
          end
          ST_DATA: begin
            r_ostate <= ST_DATA;
            if (!r_skp_pending) begin
              if (r_cnt == CNT_LAST) begin
                r_skp_pending <= 1'b1;
                r_cnt         <= '0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            if (w_xfer) begin
              r_txdata    <= iData;
              r_txk       <= iDataK;
              r_in_packet <= ~iLast;
            end else if (r_skp_pending && !r_in_packet) begin
              r_state       <= ST_SKP;
              r_ostate      <= ST_SKP;
              r_skp_pending <= 1'b0;
              r_sub         <= '0;
              r_txdata      <= SYM_COM;
              r_txk         <= 1'b1;
              r_skpact      <= 1'b1;
            end else if (iCompliance && !r_in_packet) begin
              r_state  <= ST_COMP;
              r_ostate <= ST_COMP;
              r_sub    <= 3'd1;
              r_txdata <= SYM_COM;
              r_txk    <= 1'b1;
              r_txcomp <= 1'b1;
            end
          end
          ST_SKP: begin
            r_ostate <= ST_SKP;
            r_txdata <= SYM_SKP;
            r_txk    <= 1'b1;
            r_skpact <= 1'b1;
            if (r_sub == SUB_LAST) begin
              r_state <= iCompliance ? ST_COMP : ST_DATA;
              r_sub   <= '0;
            end else begin
              r_sub <= r_sub + 3'd1;
            end
          end
          ST_COMP: begin
            if (r_sub == 3'd0 && !iCompliance) begin
              r_state  <= ST_DATA;
              r_ostate <= ST_DATA;
            end else begin
              r_ostate <= ST_COMP;
              r_txdata <= w_pat_d;
              r_txk    <= w_pat_k;
              r_txcomp <= w_pat_c;
              r_sub    <= {1'b0, r_sub[1:0] + 2'd1};
            end
          end
        endcase
      end
    end
  end

  assign oReady     = w_ready;
  assign oTxData    = r_txdata;
  assign oTxDataK   = r_txk;
  assign oTxComp    = r_txcomp;
  assign oSkpActive = r_skpact;
  assign oState     = r_ostate;

endmodule
